pc_load_logic: RTL and testbench

- Branch-resolution and PC-write-enable logic for the multi-cycle MIPS datapath.
- Combines the ALU flags (negative, zero) with the control-unit branch strobes and the unconditional PC enable.
- Produces the PC register load strobe combinationally, in the same cycle as the flags.
- Also provides a registered taken flag, a multi-strobe error flag and optional branch statistics.

---
 rtl/pc_load_pkg.sv | 26 ++
 rtl/br_cond_eval.sv | 22 ++
 rtl/pc_load_logic.sv | 89 ++++++++
 tb/tb_pc_load_logic.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_load_pkg.sv
// Shared constants for the PC load logic: branch-type indices, strobe vector type
// and the default statistics counter width.
package pc_load_pkg;

  localparam int BR_BEQ  = 0;
  localparam int BR_BNE  = 1;
  localparam int BR_BLTZ = 2;
  localparam int BR_BGTZ = 3;
  localparam int BR_BLEZ = 4;
  localparam int NUM_BR  = 5;

  localparam int CNT_W_DEFAULT = 32;

  typedef logic [NUM_BR-1:0] br_vec_t;

  // Number of branch strobes raised in one cycle.
  function automatic logic [2:0] strobe_count(input br_vec_t s);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_BR; i++) begin
      n = n + {2'b00, s[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/br_cond_eval.sv
// Purely combinational branch-condition evaluator: maps the ALU flags and the
// per-type branch strobes onto a per-type taken vector.
module br_cond_eval
  import pc_load_pkg::*;
(
  input  logic    nf,
  input  logic    zf,
  input  br_vec_t strobe,
  output br_vec_t taken
);

  // NF and ZF together are not filtered: each equation is applied literally.
  always_comb begin
    taken          = '0;
    taken[BR_BEQ]  = strobe[BR_BEQ]  & zf;
    taken[BR_BNE]  = strobe[BR_BNE]  & ~zf;
    taken[BR_BLTZ] = strobe[BR_BLTZ] & nf;
    taken[BR_BGTZ] = strobe[BR_BGTZ] & ~nf & ~zf;
    taken[BR_BLEZ] = strobe[BR_BLEZ] & (nf | zf);
  end

endmodule

// File: rtl/pc_load_logic.sv
// Branch resolution and PC write enable for the multi-cycle MIPS datapath.
// Optional branch statistics counters are enabled by defining PC_LOAD_STATS_EN.
module pc_load_logic
  import pc_load_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
)
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             NF_OUT,
  input  logic             ZF_OUT,
  input  logic             PCWrite_BLTZ,
  input  logic             PCWrite_BGTZ,
  input  logic             PCWrite_BLEZ,
  input  logic             PCWrite_BNE,
  input  logic             PCWrite_BEQ,
  input  logic             PC_EN,
  output logic             PC_LOAD,
  output logic             BR_TAKEN,
  output logic             BR_TAKEN_Q,
  output logic             MULTI_BR
`ifdef PC_LOAD_STATS_EN
  ,
  output logic [CNT_W-1:0] BR_CNT,
  output logic [CNT_W-1:0] BR_TAKEN_CNT
`endif
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("pc_load_logic: CNT_W must be at least 1");
  end

  br_vec_t strobe;
  br_vec_t taken_vec;

  always_comb begin
    strobe          = '0;
    strobe[BR_BEQ]  = PCWrite_BEQ;
    strobe[BR_BNE]  = PCWrite_BNE;
    strobe[BR_BLTZ] = PCWrite_BLTZ;
    strobe[BR_BGTZ] = PCWrite_BGTZ;
    strobe[BR_BLEZ] = PCWrite_BLEZ;
  end

  br_cond_eval u_br_cond_eval (
    .nf     (NF_OUT),
    .zf     (ZF_OUT),
    .strobe (strobe),
    .taken  (taken_vec)
  );

  // No priority among strobes; MULTI_BR only flags the overlap.
  assign BR_TAKEN = |taken_vec;
  assign PC_LOAD  = PC_EN | BR_TAKEN;
  assign MULTI_BR = (strobe_count(strobe) >= 3'd2);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      BR_TAKEN_Q <= 1'b0;
    end else begin
      BR_TAKEN_Q <= BR_TAKEN;
    end
  end

`ifdef PC_LOAD_STATS_EN
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] br_taken_cnt;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      br_cnt       <= '0;
      br_taken_cnt <= '0;
    end else begin
      if ((|strobe) && (br_cnt != {CNT_W{1'b1}})) begin
        br_cnt <= br_cnt + CNT_W'(1);
      end
      if (BR_TAKEN && (br_taken_cnt != {CNT_W{1'b1}})) begin
        br_taken_cnt <= br_taken_cnt + CNT_W'(1);
      end
    end
  end

  assign BR_CNT       = br_cnt;
  assign BR_TAKEN_CNT = br_taken_cnt;
`endif

endmodule

// File: tb/tb_pc_load_logic.sv
// Scoreboard testbench for pc_load_logic: a driver pushes expected responses from a
// flag-relation reference model, a monitor pops and compares them each cycle.
module tb_pc_load_logic;

  localparam int     TB_CNT_W = 4;
  localparam longint CNT_MAX  = (longint'(1) << TB_CNT_W) - 1;

  logic CLK;
  logic RST;
  logic NF_OUT;
  logic ZF_OUT;
  logic PCWrite_BLTZ;
  logic PCWrite_BGTZ;
  logic PCWrite_BLEZ;
  logic PCWrite_BNE;
  logic PCWrite_BEQ;
  logic PC_EN;
  logic PC_LOAD;
  logic BR_TAKEN;
  logic BR_TAKEN_Q;
  logic MULTI_BR;
`ifdef PC_LOAD_STATS_EN
  logic [TB_CNT_W-1:0] BR_CNT;
  logic [TB_CNT_W-1:0] BR_TAKEN_CNT;
`endif

  pc_load_logic #(.CNT_W(TB_CNT_W)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .NF_OUT       (NF_OUT),
    .ZF_OUT       (ZF_OUT),
    .PCWrite_BLTZ (PCWrite_BLTZ),
    .PCWrite_BGTZ (PCWrite_BGTZ),
    .PCWrite_BLEZ (PCWrite_BLEZ),
    .PCWrite_BNE  (PCWrite_BNE),
    .PCWrite_BEQ  (PCWrite_BEQ),
    .PC_EN        (PC_EN),
    .PC_LOAD      (PC_LOAD),
    .BR_TAKEN     (BR_TAKEN),
    .BR_TAKEN_Q   (BR_TAKEN_Q),
    .MULTI_BR     (MULTI_BR)
`ifdef PC_LOAD_STATS_EN
    ,
    .BR_CNT       (BR_CNT),
    .BR_TAKEN_CNT (BR_TAKEN_CNT)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    int     id;
    logic   pc_load;
    logic   br_taken;
    logic   multi_br;
    logic   taken_q;
    longint br_cnt;
    longint taken_cnt;
  } exp_t;

  exp_t exp_q[$];

  int compared   = 0;
  int mismatched = 0;
  int vec_id     = 0;

  // Model state describing what the registers should hold.
  logic   model_q    = 1'b0;
  logic   model_rst  = 1'b0;
  logic   prev_taken = 1'b0;
  logic   prev_any   = 1'b0;
  longint model_cnt  = 0;
  longint model_tcnt = 0;

  // Strobe order in s: [0]=BEQ [1]=BNE [2]=BLTZ [3]=BGTZ [4]=BLEZ.
  // The flags are viewed as relations of the ALU result against zero.
  function automatic logic ref_taken(input logic nf, input logic zf, input logic [4:0] s);
    logic lt, eq, gt, le, ne;
    lt = nf;
    eq = zf;
    ne = !zf;
    gt = !nf && !zf;
    le = lt || eq;
    return (s[0] && eq) || (s[1] && ne) || (s[2] && lt) || (s[3] && gt) || (s[4] && le);
  endfunction

  function automatic int ref_count(input logic [4:0] s);
    int n;
    n = 0;
    for (int i = 0; i < 5; i++) if (s[i]) n++;
    return n;
  endfunction

  task automatic checkOutput(input string name, input int id,
                             input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s vec %0d: got %0h, want %0h", name, id, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic nf, input logic zf, input logic [4:0] s,
                               input logic pc_en, input logic rst);
    exp_t e;
    logic taken;
    @(posedge CLK);
    if (model_rst) begin
      model_q = prev_taken;
      if (prev_any && model_cnt < CNT_MAX) model_cnt++;
      if (prev_taken && model_tcnt < CNT_MAX) model_tcnt++;
    end else begin
      model_q    = 1'b0;
      model_cnt  = 0;
      model_tcnt = 0;
    end
    #1;
    NF_OUT       = nf;
    ZF_OUT       = zf;
    PCWrite_BEQ  = s[0];
    PCWrite_BNE  = s[1];
    PCWrite_BLTZ = s[2];
    PCWrite_BGTZ = s[3];
    PCWrite_BLEZ = s[4];
    PC_EN        = pc_en;
    RST          = rst;
    if (!rst) begin
      model_q    = 1'b0;
      model_cnt  = 0;
      model_tcnt = 0;
    end
    model_rst = rst;
    taken = ref_taken(nf, zf, s);
    e.id        = vec_id;
    e.pc_load   = pc_en || taken;
    e.br_taken  = taken;
    e.multi_br  = (ref_count(s) >= 2);
    e.taken_q   = model_q;
    e.br_cnt    = model_cnt;
    e.taken_cnt = model_tcnt;
    exp_q.push_back(e);
    vec_id++;
    prev_taken = taken;
    prev_any   = (s != 5'b0);
  endtask

  // Monitor: combinational and registered outputs are settled by the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("pc_load",    e.id, {63'b0, PC_LOAD},    {63'b0, e.pc_load});
        checkOutput("br_taken",   e.id, {63'b0, BR_TAKEN},   {63'b0, e.br_taken});
        checkOutput("multi_br",   e.id, {63'b0, MULTI_BR},   {63'b0, e.multi_br});
        checkOutput("br_taken_q", e.id, {63'b0, BR_TAKEN_Q}, {63'b0, e.taken_q});
`ifdef PC_LOAD_STATS_EN
        checkOutput("br_cnt",       e.id, 64'(BR_CNT),       64'(e.br_cnt));
        checkOutput("br_taken_cnt", e.id, 64'(BR_TAKEN_CNT), 64'(e.taken_cnt));
`endif
      end
    end
  end

  initial begin
    logic [4:0] s;
    RST = 1'b0;
    NF_OUT = 1'b0;
    ZF_OUT = 1'b0;
    PCWrite_BLTZ = 1'b0;
    PCWrite_BGTZ = 1'b0;
    PCWrite_BLEZ = 1'b0;
    PCWrite_BNE = 1'b0;
    PCWrite_BEQ = 1'b0;
    PC_EN = 1'b0;

    // Reset state, then combinational outputs while reset is held.
    applyStimulus(1'b0, 1'b0, 5'b00000, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'b11111, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'b00000, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 5'b11111, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 5'b00000, 1'b1, 1'b1);

    // One strobe at a time.
    applyStimulus(1'b0, 1'b0, 5'b01000, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 5'b01000, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 5'b01000, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 5'b10000, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 5'b10000, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 5'b00010, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 5'b00010, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 5'b00001, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 5'b00100, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 5'b00100, 1'b0, 1'b1);

    // Overlapping strobes, then the registered path and a mid-cycle reset drop.
    applyStimulus(1'b0, 1'b0, 5'b11101, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 5'b00001, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 5'b00001, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 5'b00001, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'b00000, 1'b0, 1'b1);

    // Statistics sequence: 3 taken BNE cycles, 2 not-taken ones, then observe.
    applyStimulus(1'b0, 1'b0, 5'b00000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 5'b00010, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 5'b00010, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 5'b00000, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 5'b00001, 1'b0, 1'b1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) s = 5'($urandom_range(0, 31));
      else if ($urandom_range(0, 3) == 0) s = 5'b00000;
      else s = 5'b00001 << $urandom_range(0, 4);
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), s,
                    1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 39) != 0));
    end

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
